// File: rtl/secuenciador_isa.sv
// rtl/secuenciador_isa.sv - multicycle fetch/decode/exec/write-back sequencer for the R-type ISA datapath
// Optional illegal-instruction trap state enabled by defining SEC_TRAP_EN.
module secuenciador_isa #(
  parameter int IMEM_AW = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               im_req,
  output logic [IMEM_AW-1:0] im_addr,
  input  logic               im_ack,
  input  logic [31:0]        im_data,
  output logic [31:0]        instr,
  output logic               br_we,
  output logic [IMEM_AW-1:0] pc,
  output logic [CNT_W-1:0]   icount,
  output logic               busy,
  output logic               halted,
  output logic               trap
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_TRAP
  } state_t;

  state_t state, state_n;
  logic   legal_q;
  logic   is_legal;
  logic   is_halt;

  always_comb begin
    is_legal = 1'b0;
    if (instr[31:26] == 6'b000000) begin
      case (instr[5:0])
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: is_legal = 1'b1;
        default: is_legal = 1'b0;
      endcase
    end
    is_halt = (instr[31:26] == 6'b111111);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_FETCH;
      S_FETCH:  if (im_ack) state_n = S_DECODE;
      S_DECODE: begin
        if (is_halt)
          state_n = S_HALT;
        else if (is_legal)
          state_n = S_EXEC;
        else begin
`ifdef SEC_TRAP_EN
          state_n = S_TRAP;
`else
          state_n = S_EXEC;
`endif
        end
      end
      S_EXEC:   state_n = S_WB;
      S_WB:     state_n = S_FETCH;
      S_HALT:   if (start) state_n = S_FETCH;
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      icount  <= '0;
      instr   <= '0;
      legal_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc     <= '0;
            icount <= '0;
          end
        end
        S_FETCH:  if (im_ack) instr <= im_data;
        S_DECODE: legal_q <= is_legal;
        S_WB: begin
          pc <= pc + 1'b1;
          if (icount != {CNT_W{1'b1}})
            icount <= icount + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs come only from state and registers, never from im_ack/im_data.
  assign im_req  = (state == S_FETCH);
  assign im_addr = pc;
  assign br_we   = (state == S_WB) && legal_q && (instr[15:11] != 5'd0);
  assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
  assign halted  = (state == S_HALT);
`ifdef SEC_TRAP_EN
  assign trap    = (state == S_TRAP);
`else
  assign trap    = 1'b0;
`endif

endmodule

// File: tb/tb_secuenciador_isa.sv
// tb/tb_secuenciador_isa.sv - directed self-checking bench for secuenciador_isa
// Second instance (IMEM_AW=2, CNT_W=2) covers pc wrap and counter saturation.
module tb_secuenciador_isa;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SUB  = 32'h00221822;
  localparam logic [31:0] I_HALT = 32'hFC000000;
  localparam logic [31:0] I_RD0  = 32'h00220020;
  localparam logic [31:0] I_ILL  = 32'h8C220000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        im_req, im_ack, br_we, busy, halted, trap;
  logic [5:0]  im_addr, pc;
  logic [31:0] im_data, instr;
  logic [15:0] icount;

  logic        start2 = 1'b0;
  logic        im_req2, im_ack2, br_we2, busy2, halted2, trap2;
  logic [1:0]  im_addr2, pc2, icount2;
  logic [31:0] im_data2, instr2;

  logic [31:0] mem [0:63];
  logic [31:0] mem2 [0:3];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  secuenciador_isa #(.IMEM_AW(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_data(im_data), .instr(instr), .br_we(br_we), .pc(pc),
    .icount(icount), .busy(busy), .halted(halted), .trap(trap)
  );

  secuenciador_isa #(.IMEM_AW(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .im_req(im_req2), .im_addr(im_addr2),
    .im_ack(im_ack2), .im_data(im_data2), .instr(instr2), .br_we(br_we2), .pc(pc2),
    .icount(icount2), .busy(busy2), .halted(halted2), .trap(trap2)
  );

  // Memory responder: acks after ack_delay wait cycles of im_req.
  assign im_ack   = im_req && (wait_cnt == ack_delay);
  assign im_data  = mem[im_addr];
  assign im_ack2  = im_req2;
  assign im_data2 = mem2[im_addr2];

  always @(posedge clk) begin
    if (im_req && !im_ack) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_stop(output int pulses, output bit ok);
    pulses = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (br_we) pulses++;
      if (halted || trap) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    vecs++; if ({im_req, br_we, busy, halted, trap} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b want 00000", {im_req, br_we, busy, halted, trap}); end
    vecs++; if (pc !== 6'd0 || im_addr !== 6'd0) begin errs++; $display("FAIL reset_pc got pc=%0d addr=%0d want 0", pc, im_addr); end
    vecs++; if (icount !== 16'd0 || instr !== 32'd0) begin errs++; $display("FAIL reset_regs got icount=%0d instr=%h want 0", icount, instr); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    int p; bit ok;
    mem[0] = I_ADD; mem[1] = I_HALT; ack_delay = 0;
    pulse_start();
    vecs++; if (im_req !== 1'b1 || im_addr !== 6'd0) begin errs++; $display("FAIL basic_fetch got req=%b addr=%0d want 1/0", im_req, im_addr); end
    cyc();
    vecs++; if (im_req !== 1'b0 || instr !== I_ADD) begin errs++; $display("FAIL basic_decode got req=%b instr=%h want 0/%h", im_req, instr, I_ADD); end
    cyc();
    vecs++; if (br_we !== 1'b0) begin errs++; $display("FAIL basic_exec_we got %b want 0", br_we); end
    cyc();
    vecs++; if (br_we !== 1'b1) begin errs++; $display("FAIL basic_wb_we got %b want 1", br_we); end
    cyc();
    vecs++; if (br_we !== 1'b0 || pc !== 6'd1 || icount !== 16'd1) begin errs++; $display("FAIL basic_after got we=%b pc=%0d icount=%0d want 0/1/1", br_we, pc, icount); end
    run_until_stop(p, ok);
    vecs++; if (!ok || halted !== 1'b1 || busy !== 1'b0 || pc !== 6'd1 || icount !== 16'd1) begin errs++; $display("FAIL basic_halt got ok=%b halted=%b busy=%b pc=%0d icount=%0d want 1/1/0/1/1", ok, halted, busy, pc, icount); end
  endtask

  task automatic test_ack_delay();
    int p; bit ok; int bad;
    mem[0] = I_ADD; mem[1] = I_HALT; ack_delay = 3;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (im_req !== 1'b1 || im_addr !== 6'd0 || br_we !== 1'b0) bad++;
      cyc();
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL delay_hold got %0d bad cycles want 0", bad); end
    vecs++; if (im_req !== 1'b0 || instr !== I_ADD) begin errs++; $display("FAIL delay_decode got req=%b instr=%h want 0/%h", im_req, instr, I_ADD); end
    cyc(); cyc();
    vecs++; if (br_we !== 1'b1) begin errs++; $display("FAIL delay_we got %b want 1", br_we); end
    run_until_stop(p, ok);
    vecs++; if (!ok || icount !== 16'd1) begin errs++; $display("FAIL delay_halt got ok=%b icount=%0d want 1/1", ok, icount); end
    ack_delay = 0;
  endtask

  task automatic test_program();
    int p; bit ok;
    mem[0] = I_ADD; mem[1] = I_SUB; mem[2] = I_HALT;
    pulse_start();
    run_until_stop(p, ok);
    vecs++; if (!ok || p != 2) begin errs++; $display("FAIL prog_pulses got ok=%b pulses=%0d want 1/2", ok, p); end
    vecs++; if (halted !== 1'b1 || icount !== 16'd2 || pc !== 6'd2) begin errs++; $display("FAIL prog_state got halted=%b icount=%0d pc=%0d want 1/2/2", halted, icount, pc); end
    pulse_start();
    vecs++; if (im_req !== 1'b1 || pc !== 6'd0 || icount !== 16'd0) begin errs++; $display("FAIL prog_restart got req=%b pc=%0d icount=%0d want 1/0/0", im_req, pc, icount); end
    run_until_stop(p, ok);
    vecs++; if (!ok || p != 2 || icount !== 16'd2) begin errs++; $display("FAIL prog_rerun got ok=%b pulses=%0d icount=%0d want 1/2/2", ok, p, icount); end
  endtask

  task automatic test_rd0();
    int p; bit ok;
    mem[0] = I_RD0; mem[1] = I_HALT;
    pulse_start();
    run_until_stop(p, ok);
    vecs++; if (!ok || p != 0 || icount !== 16'd1) begin errs++; $display("FAIL rd0 got ok=%b pulses=%0d icount=%0d want 1/0/1", ok, p, icount); end
  endtask

  task automatic test_illegal();
    int p; bit ok;
    mem[0] = I_ILL; mem[1] = I_HALT;
    pulse_start();
    run_until_stop(p, ok);
`ifdef SEC_TRAP_EN
    vecs++; if (!ok || trap !== 1'b1 || busy !== 1'b0 || p != 0) begin errs++; $display("FAIL ill_trap got ok=%b trap=%b busy=%b pulses=%0d want 1/1/0/0", ok, trap, busy, p); end
    vecs++; if (pc !== 6'd0 || icount !== 16'd0) begin errs++; $display("FAIL ill_regs got pc=%0d icount=%0d want 0/0", pc, icount); end
    pulse_start(); cyc();
    vecs++; if (trap !== 1'b1 || im_req !== 1'b0) begin errs++; $display("FAIL ill_sticky got trap=%b req=%b want 1/0", trap, im_req); end
    rst = 1'b1; cyc(); rst = 1'b0;
    vecs++; if (trap !== 1'b0) begin errs++; $display("FAIL ill_clear got %b want 0", trap); end
`else
    vecs++; if (!ok || halted !== 1'b1 || p != 0 || trap !== 1'b0) begin errs++; $display("FAIL ill_nop got ok=%b halted=%b pulses=%0d trap=%b want 1/1/0/0", ok, halted, p, trap); end
    vecs++; if (icount !== 16'd1 || pc !== 6'd1) begin errs++; $display("FAIL ill_regs got icount=%0d pc=%0d want 1/1", icount, pc); end
`endif
  endtask

  task automatic test_rst_mid();
    mem[0] = I_ADD; mem[1] = I_HALT;
    pulse_start(); cyc(); cyc(); cyc();
    vecs++; if (br_we !== 1'b1) begin errs++; $display("FAIL rstwb_pre got %b want 1", br_we); end
    rst = 1'b1; cyc(); rst = 1'b0;
    vecs++; if ({br_we, busy, im_req, halted} !== 4'b0 || pc !== 6'd0 || icount !== 16'd0 || instr !== 32'd0) begin errs++; $display("FAIL rstwb_post got flags=%b pc=%0d icount=%0d instr=%h want 0", {br_we, busy, im_req, halted}, pc, icount, instr); end
    pulse_start();
    rst = 1'b1; cyc(); rst = 1'b0;
    vecs++; if (instr !== 32'd0 || busy !== 1'b0) begin errs++; $display("FAIL rstfetch got instr=%h busy=%b want 0/0", instr, busy); end
    rst = 1'b1; start = 1'b1; cyc(); rst = 1'b0; start = 1'b0;
    vecs++; if (busy !== 1'b0 || im_req !== 1'b0) begin errs++; $display("FAIL rststart got busy=%b req=%b want 0/0", busy, im_req); end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [1:0] exp_a;
    logic [1:0] exp_c;
    bad = 0;
    start2 = 1'b1; cyc(); start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_a = i[1:0];
      exp_c = (i > 3) ? 2'd3 : i[1:0];
      if (im_req2 !== 1'b1 || im_addr2 !== exp_a || icount2 !== exp_c) begin
        bad++;
        $display("FAIL wrap_fetch%0d got addr=%0d icount=%0d want %0d/%0d", i, im_addr2, icount2, exp_a, exp_c);
      end
      cyc(); cyc(); cyc();
      if (br_we2 !== 1'b1) begin
        bad++;
        $display("FAIL wrap_we%0d got %b want 1", i, br_we2);
      end
      cyc();
    end
    vecs++; if (bad != 0) errs++;
    vecs++; if (pc2 !== 2'd2 || icount2 !== 2'd3) begin errs++; $display("FAIL wrap_final got pc=%0d icount=%0d want 2/3", pc2, icount2); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = I_HALT;
    for (int i = 0; i < 4; i++) mem2[i] = I_ADD;
    test_reset();
    test_basic();
    test_ack_delay();
    test_program();
    test_rd0();
    test_illegal();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
